vga_timing: RTL and testbench
=============================

# vga_timing

Pixel-timing generator that sits directly upstream of the graphics stage. It owns the horizontal and vertical raster counters and the animation frame counter. It produces the pixel coordinates the graphics stage decodes into colour, plus sync and data-enable outputs delayed to line up with that stage's registered colour output. Moving the counters here lets multiple drawing stages share one raster and lets the pixel rate be a clock-enable rather than the full clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT_PORCH, 16, pixels after active before hsync
- H_SYNC_PULSE, 96, hsync width in pixels
- H_BACK_PORCH, 48, pixels after hsync before next line
- V_ACTIVE, 480, visible lines per frame
- V_FRONT_PORCH, 10; V_SYNC_PULSE, 2; V_BACK_PORCH, 33, vertical equivalents in lines
- HSYNC_ACTIVE, 1'b0, hsync level during pulse
- VSYNC_ACTIVE, 1'b0, vsync level during pulse
- SYNC_DELAY, 1, pix_en ticks by which hsync/vsync/de lag the counters (0..4)
- FRAME_BITS, 5, frame counter width
- clk  in  1  pixel/system clock
- rst_n  in  1  reset, asynchronous, active-low
- pix_en  in  1  pixel tick; counters and delay line advance only when high
- pixel_x  out  clog2(H_TOTAL)  current column, 0..H_TOTAL-1
- pixel_y  out  clog2(V_TOTAL)  current line, 0..V_TOTAL-1
- active  out  1  pixel_x < H_ACTIVE && pixel_y < V_ACTIVE, undelayed
- line_start  out  1  pix_en && pixel_x == 0
- frame_start  out  1  pix_en && pixel_x == 0 && pixel_y == 0
- frame_count  out  FRAME_BITS  completed-frame count, wraps
- hsync, vsync, de  out  1 each  delayed sync levels and delayed active

## Operation
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- On pix_en: if pixel_x == H_TOTAL-1 then pixel_x←0 and pixel_y advances; otherwise pixel_x←pixel_x+1.
- pixel_y advance: if pixel_y == V_TOTAL-1 then pixel_y←0 and frame_count←frame_count+1 (mod 2^FRAME_BITS); otherwise pixel_y+1.
- Raw hsync is HSYNC_ACTIVE when H_ACTIVE+H_FRONT_PORCH ≤ pixel_x < H_ACTIVE+H_FRONT_PORCH+H_SYNC_PULSE, else inverted. Raw vsync uses the same window on pixel_y with the V parameters.
- {raw hsync, raw vsync, active} pass through a SYNC_DELAY-deep shift register clocked by pix_en. SYNC_DELAY=0 drives outputs combinationally from the counters.
- active, line_start and frame_start are combinational from registered counters and are not delayed.
- pix_en low: all state holds, and line_start and frame_start are 0.

## Timing
- Reset (async assert, sync release to clk): pixel_x=0, pixel_y=0, frame_count=0. Every delay stage holds hsync=~HSYNC_ACTIVE, vsync=~VSYNC_ACTIVE, de=0.
- Counter update is visible the clk edge after pix_en is sampled high.
- With pix_en tied high, hsync, vsync and de equal the raw values from SYNC_DELAY cycles earlier.
- Frame wrap: pixel_x=799, pixel_y=524 with pix_en → next cycle 0/0, frame_count+1, frame_start high that cycle if pix_en.
- frame_count 2^FRAME_BITS-1 wraps to 0 with no flag.
- Reset mid-line clears the counters and delay line immediately. The first tick after release is x=0, y=0.

## Structure
- Package vga_timing_pkg holds the default 640x480@60 constants, H_TOTAL/V_TOTAL helper functions and the bit-width localparams derived with $clog2.
- Sub-module sync_delay_line: parameterised width (3) and depth (SYNC_DELAY) shift register with enable and reset value input. Depth 0 is a wire.
- Top holds the counters, window compares and strobes.

## Test plan
- Reset while pix_en=1 at x=300 → outputs immediately 0/0, hsync=vsync=1, de=0. After release, pixel_x counts 0,1,2 on successive cycles.
- pix_en=1 constant, SYNC_DELAY=1 → hsync low exactly while pixel_x reads 657..752 (96 cycles). de high while pixel_x reads 1..640 on lines 0..479.
- Run one full frame → pixel_x wraps 799→0 with pixel_y+1. vsync low for 2 lines starting when line 490 begins, lagging by 1 tick. frame_count 0→1 at the y=524→0 transition. frame_start pulses exactly once.
- pix_en toggling 1,0,1,0 → counters advance every other cycle. line_start is never high on a pix_en=0 cycle. Sync pulse length doubles in clk cycles.
- FRAME_BITS=5, run 32 frames → frame_count wraps 31→0. Bit 4 is high for frames 16..31.
- SYNC_DELAY=0 and 3 → hsync edge lags the x=656 counter state by 0 and 3 ticks respectively.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg : 640x480@60 defaults, total helpers, widths -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_PULSE  = 96;
  localparam int DEF_H_BACK_PORCH  = 48;
  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_PULSE  = 2;
  localparam int DEF_V_BACK_PORCH  = 33;
  localparam int DEF_SYNC_DELAY    = 1;
  localparam int DEF_FRAME_BITS    = 5;

  function automatic int h_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = h_total(DEF_H_ACTIVE, DEF_H_FRONT_PORCH,
                                       DEF_H_SYNC_PULSE, DEF_H_BACK_PORCH);
  localparam int DEF_V_TOTAL = v_total(DEF_V_ACTIVE, DEF_V_FRONT_PORCH,
                                       DEF_V_SYNC_PULSE, DEF_V_BACK_PORCH);
  localparam int DEF_X_BITS  = $clog2(DEF_H_TOTAL);
  localparam int DEF_Y_BITS  = $clog2(DEF_V_TOTAL);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bits_t;

  localparam int SYNC_WIDTH = $bits(sync_bits_t);

endpackage

`default_nettype wire

// File: rtl/vga_timing_sync_delay_line.sv
// ----------------------------------------------------------------------------
// sync_delay_line : enabled shift register, depth 0 is a plain wire -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, en, rst_val};
      assign dout        = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
// ----------------------------------------------------------------------------
// vga_timing : raster/frame counters, strobes, delayed sync and de -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE      = DEF_H_ACTIVE,
  parameter int   H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int   H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
  parameter int   H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int   V_ACTIVE      = DEF_V_ACTIVE,
  parameter int   V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int   V_SYNC_PULSE  = DEF_V_SYNC_PULSE,
  parameter int   V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter logic HSYNC_ACTIVE  = 1'b0,
  parameter logic VSYNC_ACTIVE  = 1'b0,
  parameter int   SYNC_DELAY    = DEF_SYNC_DELAY,
  parameter int   FRAME_BITS    = DEF_FRAME_BITS,
  localparam int  H_TOTAL = h_total(H_ACTIVE, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH),
  localparam int  V_TOTAL = v_total(V_ACTIVE, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH),
  localparam int  X_BITS  = $clog2(H_TOTAL),
  localparam int  Y_BITS  = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  output logic [X_BITS-1:0]     pixel_x,
  output logic [Y_BITS-1:0]     pixel_y,
  output logic                  active,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [FRAME_BITS-1:0] frame_count,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_TOTAL - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_TOTAL - 1);

  // Sync windows use inclusive last positions so they always fit the counter width.
  localparam logic [X_BITS-1:0] HS_FIRST = X_BITS'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [X_BITS-1:0] HS_LAST  = X_BITS'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE - 1);
  localparam logic [Y_BITS-1:0] VS_FIRST = Y_BITS'(V_ACTIVE + V_FRONT_PORCH);
  localparam logic [Y_BITS-1:0] VS_LAST  = Y_BITS'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE - 1);
  localparam logic [X_BITS:0]   X_ACT    = (X_BITS+1)'(H_ACTIVE);
  localparam logic [Y_BITS:0]   Y_ACT    = (Y_BITS+1)'(V_ACTIVE);

  localparam sync_bits_t SYNC_IDLE = '{hsync: ~HSYNC_ACTIVE, vsync: ~VSYNC_ACTIVE, de: 1'b0};

  sync_bits_t raw_sync;
  sync_bits_t dly_sync;
  logic       x_last;
  logic       y_last;

  assign x_last = (pixel_x == X_LAST);
  assign y_last = (pixel_y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_count <= '0;
    end else if (pix_en) begin
      if (x_last) begin
        pixel_x <= '0;
        if (y_last) begin
          pixel_y     <= '0;
          frame_count <= frame_count + 1'b1;
        end else begin
          pixel_y <= pixel_y + 1'b1;
        end
      end else begin
        pixel_x <= pixel_x + 1'b1;
      end
    end
  end

  always_comb begin
    active      = ({1'b0, pixel_x} < X_ACT) && ({1'b0, pixel_y} < Y_ACT);
    line_start  = pix_en && (pixel_x == '0);
    frame_start = line_start && (pixel_y == '0);

    raw_sync.hsync = ((pixel_x >= HS_FIRST) && (pixel_x <= HS_LAST)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    raw_sync.vsync = ((pixel_y >= VS_FIRST) && (pixel_y <= VS_LAST)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    raw_sync.de    = active;
  end

  sync_delay_line #(
    .WIDTH (SYNC_WIDTH),
    .DEPTH (SYNC_DELAY)
  ) u_sync_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pix_en),
    .rst_val (SYNC_IDLE),
    .din     (raw_sync),
    .dout    (dly_sync)
  );

  assign hsync = dly_sync.hsync;
  assign vsync = dly_sync.vsync;
  assign de    = dly_sync.de;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ----------------------------------------------------------------------------
// tb_vga_timing : tick-count reference model plus directed literal checks -- rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b1;
  bit   checking = 1'b1;
  int   n = 0;
  int   passes = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Default geometry at three delays, plus a tiny active-high raster for frame-level behaviour.
  logic [9:0] d1_x, d0_x, d3_x, d1_y, d0_y, d3_y;
  logic [4:0] d1_fc, d0_fc, d3_fc, s_fc;
  logic d1_act, d1_ls, d1_fs, d1_hs, d1_vs, d1_de;
  logic d0_act, d0_ls, d0_fs, d0_hs, d0_vs, d0_de;
  logic d3_act, d3_ls, d3_fs, d3_hs, d3_vs, d3_de;
  logic [3:0] s_x;
  logic [2:0] s_y;
  logic s_act, s_ls, s_fs, s_hs, s_vs, s_de;

  vga_timing #(.SYNC_DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pixel_x(d1_x), .pixel_y(d1_y),
    .active(d1_act), .line_start(d1_ls), .frame_start(d1_fs), .frame_count(d1_fc),
    .hsync(d1_hs), .vsync(d1_vs), .de(d1_de));

  vga_timing #(.SYNC_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pixel_x(d0_x), .pixel_y(d0_y),
    .active(d0_act), .line_start(d0_ls), .frame_start(d0_fs), .frame_count(d0_fc),
    .hsync(d0_hs), .vsync(d0_vs), .de(d0_de));

  vga_timing #(.SYNC_DELAY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pixel_x(d3_x), .pixel_y(d3_y),
    .active(d3_act), .line_start(d3_ls), .frame_start(d3_fs), .frame_count(d3_fc),
    .hsync(d3_hs), .vsync(d3_vs), .de(d3_de));

  vga_timing #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1), .SYNC_DELAY(2), .FRAME_BITS(5)
  ) duts (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pixel_x(s_x), .pixel_y(s_y),
    .active(s_act), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc),
    .hsync(s_hs), .vsync(s_vs), .de(s_de));

  // Model state: pixel ticks accepted since the last reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      n <= 0;
    else if (pix_en) n <= n + 1;
  end

  task automatic chk(input string nm, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t tick=%0d)", nm, actual, expected, $time, n);
  endtask

  task automatic check_model(input string nm,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input bit hpol, input bit vpol, input int dly, input int fb,
                             input int ax, input int ay, input bit aact, input bit als,
                             input bit afs, input int afc, input bit ahs, input bit avs,
                             input bit ade);
    int ht, vt, x, y, m, xm, ym;
    bit ehs, evs, ede, els;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    x   = n % ht;
    y   = (n / ht) % vt;
    els = pix_en && (x == 0);
    m   = n - dly;
    if (m < 0) begin
      ehs = ~hpol;
      evs = ~vpol;
      ede = 1'b0;
    end else begin
      xm  = m % ht;
      ym  = (m / ht) % vt;
      ehs = (xm >= ha + hf && xm < ha + hf + hs) ? hpol : ~hpol;
      evs = (ym >= va + vf && ym < va + vf + vs) ? vpol : ~vpol;
      ede = (xm < ha) && (ym < va);
    end
    chk({nm, ".pixel_x"},     ax,   x);
    chk({nm, ".pixel_y"},     ay,   y);
    chk({nm, ".active"},      aact, (x < ha) && (y < va));
    chk({nm, ".line_start"},  als,  els);
    chk({nm, ".frame_start"}, afs,  els && (y == 0));
    chk({nm, ".frame_count"}, afc,  (n / (ht * vt)) % (1 << fb));
    chk({nm, ".hsync"},       ahs,  ehs);
    chk({nm, ".vsync"},       avs,  evs);
    chk({nm, ".de"},          ade,  ede);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_model("d1", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1, 5,
                  d1_x, d1_y, d1_act, d1_ls, d1_fs, d1_fc, d1_hs, d1_vs, d1_de);
      check_model("d0", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0, 5,
                  d0_x, d0_y, d0_act, d0_ls, d0_fs, d0_fc, d0_hs, d0_vs, d0_de);
      check_model("d3", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 3, 5,
                  d3_x, d3_y, d3_act, d3_ls, d3_fs, d3_fc, d3_hs, d3_vs, d3_de);
      check_model("small", 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1, 2, 5,
                  s_x, s_y, s_act, s_ls, s_fs, s_fc, s_hs, s_vs, s_de);
    end
  end

  // Finds the first hsync fall on each default instance and the low length (in clk cycles) on dut1.
  task automatic measure(input bit toggle, input int max_cyc,
                         output int fx1, output int fx0, output int fx3, output int len1);
    bit p1, p0, p3, done1;
    fx1 = -1; fx0 = -1; fx3 = -1; len1 = 0; done1 = 1'b0;
    p1 = d1_hs; p0 = d0_hs; p3 = d3_hs;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk);
      #2 pix_en = toggle ? ~pix_en : 1'b1;
      @(negedge clk);
      if (fx1 < 0 && p1 && !d1_hs) fx1 = int'(d1_x);
      if (fx0 < 0 && p0 && !d0_hs) fx0 = int'(d0_x);
      if (fx3 < 0 && p3 && !d3_hs) fx3 = int'(d3_x);
      if (fx1 >= 0 && !done1) begin
        if (!d1_hs) len1++;
        else        done1 = 1'b1;
      end
      p1 = d1_hs; p0 = d0_hs; p3 = d3_hs;
      if (done1 && fx0 >= 0 && fx3 >= 0) break;
    end
  endtask

  initial begin
    int fx1, fx0, fx3, len1, fs_cnt;
    bit found;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 1000 && n != 300; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_x", int'(d1_x), 300);

    // Asynchronous reset mid-line must clear outputs before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_x",  int'(d1_x),  0);
    chk("rst_y",  int'(d1_y),  0);
    chk("rst_hs", int'(d1_hs), 1);
    chk("rst_vs", int'(d1_vs), 1);
    chk("rst_de", int'(d1_de), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); chk("post_rst_x0", int'(d1_x), 0);
    @(negedge clk); chk("post_rst_x1", int'(d1_x), 1);
    @(negedge clk); chk("post_rst_x2", int'(d1_x), 2);

    measure(1'b0, 2000, fx1, fx0, fx3, len1);
    chk("hs_fall_x_delay1", fx1, 657);
    chk("hs_fall_x_delay0", fx0, 656);
    chk("hs_fall_x_delay3", fx3, 659);
    chk("hs_low_len",       len1, 96);

    measure(1'b1, 4000, fx1, fx0, fx3, len1);
    chk("hs_low_len_half_rate", len1, 192);

    @(posedge clk);
    #2 pix_en = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 10000 && !found; i++) begin
      @(negedge clk);
      found = (s_fc == 5'd31);
    end
    chk("small_reached_fc31", int'(found), 1);
    for (int i = 0; i < 300 && s_fc == 5'd31; i++) @(negedge clk);
    chk("small_fc_wrap", int'(s_fc), 0);
    chk("small_wrap_fs", int'(s_fs), 1);
    chk("small_wrap_x",  int'(s_x),  0);
    chk("small_wrap_y",  int'(s_y),  0);

    fs_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      if (s_fs) fs_cnt++;
      @(negedge clk);
    end
    chk("small_fs_per_frame", fs_cnt, 1);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
